// File: rtl/tt_um_up_down_counter.sv
// Loadable up/down counter with async active-high reset.
// Per-edge priority: load, then count up/down, then hold.

module tt_um_up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             set,
    input  logic [WIDTH-1:0] set_value,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_UP,
        ACT_DOWN
    } action_e;

    action_e          action;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        // NOTE: defaults first so every path assigns a value and no latch is inferred.
        action     = ACT_HOLD;
        count_next = count;
        if (set) begin
            action = ACT_LOAD;
        end else if (enable) begin
            action = up_down ? ACT_UP : ACT_DOWN;
        end

        // Wrap in both directions is the natural modulo-2^WIDTH overflow.
        unique case (action)
            ACT_LOAD: count_next = set_value;
            ACT_UP:   count_next = count + WIDTH'(1);
            ACT_DOWN: count_next = count - WIDTH'(1);
            default:  count_next = count;
        endcase
    end

    // count is the only state and comes straight from this register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment for state so all flops update together at the edge.
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_tt_um_up_down_counter.sv
// Self-checking bench for tt_um_up_down_counter: vector table, wrap loops,
// and hand-written asynchronous reset sequences, scored through a queue.

module tb_tt_um_up_down_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       set;
    logic [3:0] set_value;
    logic       up_down;
    logic [3:0] count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       set;
        logic       enable;
        logic       up_down;
        logic [3:0] set_value;
        logic [3:0] expected;
    } vec_t;

    typedef struct {
        logic [3:0] expected;
        string      tag;
    } sb_t;

    sb_t sb_q[$];

    tt_um_up_down_counter #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .set       (set),
        .set_value (set_value),
        .up_down   (up_down),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors required completion", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] required);
        n_vec++;
        if (actual !== required) begin
            n_err++;
            $display("FAIL %s: count=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic drive(input vec_t v, input string tag);
        sb_t e;
        set       = v.set;
        enable    = v.enable;
        up_down   = v.up_down;
        set_value = v.set_value;
        e.expected = v.expected;
        e.tag      = tag;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        sb_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: count=%0d required=<queued entry>", count);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, count, e.expected);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v, tag);
        @(posedge clk);
        #1;
        sample();
    endtask

    vec_t tbl_load[4];
    vec_t tbl_hold[6];

    initial begin
        // {set, enable, up_down, set_value, expected}
        tbl_load[0] = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd0};
        tbl_load[1] = '{1'b1, 1'b1, 1'b1, 4'd9,  4'd9};  // load beats count
        tbl_load[2] = '{1'b0, 1'b0, 1'b0, 4'd15, 4'd9};  // set_value ignored
        tbl_load[3] = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd0};

        tbl_hold[0] = '{1'b1, 1'b0, 1'b0, 4'd7,  4'd7};
        tbl_hold[1] = '{1'b0, 1'b0, 1'b0, 4'd3,  4'd7};  // hold, up_down low
        tbl_hold[2] = '{1'b0, 1'b0, 1'b1, 4'd12, 4'd7};  // hold, up_down high
        tbl_hold[3] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd8};
        tbl_hold[4] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd7};  // direction flips next edge
        tbl_hold[5] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd8};

        reset     = 1'b1;
        enable    = 1'b1;
        set       = 1'b1;
        set_value = 4'hA;
        up_down   = 1'b1;

        #1;
        check("reset_before_edge", count, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold_%0d", i), count, 4'd0);
        end

        @(negedge clk);
        reset  = 1'b0;
        set    = 1'b0;
        enable = 1'b0;

        for (int i = 0; i < 4; i++)
            apply(tbl_load[i], $sformatf("load_vec_%0d", i));

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v = '{1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'((i + 1) % 16)};
            apply(v, $sformatf("count_up_%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v = '{1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'(((4 - (i + 1)) % 16 + 16) % 16)};
            apply(v, $sformatf("count_down_%0d", i));
        end

        for (int i = 0; i < 6; i++)
            apply(tbl_hold[i], $sformatf("hold_vec_%0d", i));

        // Reach 5 while counting up, then hit reset between edges.
        apply('{1'b1, 1'b0, 1'b1, 4'd4, 4'd4}, "preload_4");
        apply('{1'b0, 1'b1, 1'b1, 4'd0, 4'd5}, "count_to_5");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_cycle", count, 4'd0);
        @(posedge clk);
        #1;
        check("reset_overrides_enable", count, 4'd0);

        @(negedge clk);
        reset = 1'b0;
        drive('{1'b0, 1'b1, 1'b1, 4'd0, 4'd1}, "resume_after_reset");
        @(posedge clk);
        #1;
        sample();

        apply('{1'b0, 1'b1, 1'b1, 4'd0, 4'd2}, "resume_second_step");

        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover: entries=%0d required=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_up_down_counter.md
TT_UM_UP_DOWN_COUNTER -- requirements
Module: tt_um_up_down_counter

Interface
- REQ-001: Parameter WIDTH, default 4, SHALL set the counter and load-value bit width; all port widths below SHALL use WIDTH = 4.
- REQ-002: Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge only.
- REQ-003: Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
- REQ-004: Port enable, input, 1 bit, SHALL allow counting when 1.
- REQ-005: Port set, input, 1 bit, SHALL request a synchronous load of set_value when 1.
- REQ-006: Port set_value, input, 4 bits, SHALL be the value loaded when set is 1.
- REQ-007: Port up_down, input, 1 bit, SHALL select the count direction: 1 = up, 0 = down.
- REQ-008: Port count, output, 4 bits, SHALL be the current counter value, driven directly from a register with no combinational path from inputs.

Function
- REQ-009: Each rising clk edge with reset = 0 SHALL apply exactly one action, highest priority first: set, then enable, then hold.
- REQ-010: set = 1 SHALL give count <= set_value on that edge, regardless of enable and up_down.
- REQ-011: set = 0, enable = 1, up_down = 1 SHALL give count <= count + 1, modulo 16.
- REQ-012: set = 0, enable = 1, up_down = 0 SHALL give count <= count - 1, modulo 16.
- REQ-013: set = 0 and enable = 0 SHALL hold count unchanged.
- REQ-014: Counting up SHALL wrap from 15 to 0 with no flag, stall or saturation.
- REQ-015: Counting down SHALL wrap from 0 to 15 with no flag, stall or saturation.
- REQ-016: Latency SHALL be one cycle: an action sampled at edge N SHALL be visible on count after edge N.
- REQ-017: A change of up_down while enable = 1 SHALL take effect on the next edge; the step SHALL be +1 or -1 per cycle only, never skipped or doubled.
- REQ-018: set_value SHALL be ignored whenever set = 0.
- REQ-019: There SHALL be no internal state other than count.

Reset
- REQ-020: reset = 1 SHALL force count to 0 immediately, without waiting for a clock edge.
- REQ-021: count SHALL stay 0 for as long as reset = 1, overriding set and enable.
- REQ-022: Reset asserted mid-count SHALL abort the operation; after reset deasserts, counting SHALL resume from 0 on the first edge with enable = 1.
- REQ-023: Reset deassertion SHALL be applied away from the clk rising edge, so the first post-reset edge is unambiguous.

Verification
- REQ-024: Hold reset = 1 for 5 cycles with enable = 1 and set = 1 -> count = 0 throughout, including before the first clock edge.
- REQ-025: Release reset, then pulse set = 1 for 1 cycle with set_value = 0 -> count = 0; then set = 1 with set_value = 9 and enable = 1 -> count = 9, showing the load wins over counting.
- REQ-026: From 0, enable = 1, up_down = 1 for 20 cycles -> count = 0,1,…,15,0,1,2,3,4, ending at 4 with the 15->0 wrap checked.
- REQ-027: From 4, up_down = 0 for 20 cycles -> count = 3,2,1,0,15,…,1,0, ending at 0 with the 0->15 wrap checked.
- REQ-028: With count = 7, set enable = 0 for 2 cycles with up_down toggling -> count stays 7.
- REQ-029: Counting up at count = 5, assert reset between clock edges -> count = 0 before the next edge; after release with enable = 1 -> count = 1 after the first edge.
